// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Word-level front end for a bit-serial adder slice.
// It accepts a W-bit operand pair plus carry-in on a valid/ready handshake.
// It feeds the slice LSB-first with propagate, generate, carry-select and
// carry-in bits. It collects the slice's serial sum and final carry back into
// a W-bit result, which it returns on a second valid/ready handshake.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b, cin)
//   out_valid / out_ready result handshake (result, cout)
//   s_c_sel, s_in_xor,    drive to the slice
//   s_in_and, s_cin
//   s_sum, s_cout         returned from the slice
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         s_c_sel,
    output logic         s_in_xor,
    output logic         s_in_and,
    output logic         s_cin,
    input  logic         s_sum,
    input  logic         s_cout
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          cin_q, cin_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;

    // Step k presents propagate bit k and generate bit k-1.
    // Padding the vectors lets cnt index them directly.
    // Position W of p_vec is 0, and position 0 of g_vec is 0.
    logic [W:0] p_vec;
    logic [W:0] g_vec;
    logic [W-1:0] sum_hit;

    assign p_vec = {1'b0, a_q ^ b_q};
    assign g_vec = {a_q & b_q, 1'b0};

    // The sum bit for position gi arrives one step after its propagate bit,
    // which is step gi+1.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_sum_hit
            assign sum_hit[gi] = (cnt_q == CW'(gi + 1));
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        result_d = result_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    cin_d    = cin;
                    result_d = '0;
                    cout_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                for (int i = 0; i < W; i++) begin
                    if (sum_hit[i]) begin
                        result_d[i] = s_sum;
                    end
                end
                if (cnt_q == CW'(W)) begin
                    cout_d  = s_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    logic in_shift;
    assign in_shift = (state_q == SHIFT);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;

    // Step 0 loads the word carry-in into the slice (c_sel=0).
    // A stale carry left by an aborted operation can therefore never leak
    // into the next word.
    assign s_c_sel  = in_shift & (cnt_q != '0);
    assign s_cin    = in_shift & (cnt_q == '0) & cin_q;
    assign s_in_xor = in_shift & p_vec[cnt_q];
    assign s_in_and = in_shift & g_vec[cnt_q];

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Bench for serial_add_ctrl. It builds a W=8 and a W=1 instance, and each
// instance drives a behavioural bit-serial slice.
// Expected sums come from integer addition and are pushed to a queue at
// acceptance. Each entry is popped and compared when the result is presented.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- W = 8 instance ----------------
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [7:0] a = '0, b = '0, result;
    logic       cin = 1'b0, cout;
    logic       s_c_sel, s_in_xor, s_in_and, s_cin, s_sum, s_cout;

    serial_add_ctrl #(.W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout),
        .s_c_sel(s_c_sel), .s_in_xor(s_in_xor), .s_in_and(s_in_and),
        .s_cin(s_cin), .s_sum(s_sum), .s_cout(s_cout)
    );

    // Slice model: registered propagate bit and carry.
    // The sum appears one cycle after its propagate bit. The carry-out is
    // combinational from the current generate bit and the registered state.
    logic sp_q, sc_q;
    assign s_sum  = sp_q ^ sc_q;
    assign s_cout = s_in_and | (sp_q & sc_q);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= 1'b0;
            sc_q <= 1'b0;
        end else begin
            sp_q <= s_in_xor;
            sc_q <= s_c_sel ? s_cout : s_cin;
        end
    end

    // ---------------- W = 1 instance ----------------
    logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
    logic [0:0] a1 = '0, b1 = '0, result1;
    logic       cin1 = 1'b0, cout1;
    logic       t_c_sel, t_in_xor, t_in_and, t_cin, t_sum, t_cout;

    serial_add_ctrl #(.W(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .cout(cout1),
        .s_c_sel(t_c_sel), .s_in_xor(t_in_xor), .s_in_and(t_in_and),
        .s_cin(t_cin), .s_sum(t_sum), .s_cout(t_cout)
    );

    logic tp_q, tc_q;
    assign t_sum  = tp_q ^ tc_q;
    assign t_cout = t_in_and | (tp_q & tc_q);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tp_q <= 1'b0;
            tc_q <= 1'b0;
        end else begin
            tp_q <= t_in_xor;
            tc_q <= t_c_sel ? t_cout : t_cin;
        end
    end

    // Scoreboards hold {cout, result}.
    logic [8:0] sb[$];
    logic [1:0] sb1[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One W=8 operation: wait until the result is presented, then check the
    // latency, the c_sel pattern and the scoreboard entry.
    // With hold>0, backpressure is applied for that many cycles.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input int hold, input string tag);
        logic [8:0] exp;
        logic [8:0] csel;
        int lat;
        check({tag, "_in_ready_pre"}, in_ready, 1);
        a = ta; b = tb_; cin = tc;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        tick();
        sb.push_back({1'b0, ta} + {1'b0, tb_} + {8'd0, tc});
        in_valid = 1'b0;
        a = 8'($urandom_range(255, 0));
        b = 8'($urandom_range(255, 0));
        cin = 1'($urandom_range(1, 0));
        csel = '0;
        csel[0] = s_c_sel;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
            if (lat <= 8) csel[lat] = s_c_sel;
        end
        check({tag, "_latency"}, lat, 9);
        check({tag, "_csel_seq"}, csel, 9'b1_1111_1110);
        exp = sb.pop_front();
        check({tag, "_result"}, result, exp[7:0]);
        check({tag, "_cout"}, cout, exp[8]);
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                a = 8'hAA; b = 8'h01; in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_ready"}, in_ready, 0);
            check({tag, "_hold_result"}, {cout, result}, exp);
        end
        out_ready = 1'b1;
        tick();
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_ready"}, in_ready, 1);
    endtask

    task automatic run_op1(input logic ta, input logic tb_, input logic tc, input string tag);
        logic [1:0] exp;
        int lat;
        a1 = ta; b1 = tb_; cin1 = tc;
        in_valid1 = 1'b1;
        tick();
        sb1.push_back({1'b0, ta} + {1'b0, tb_} + {1'b0, tc});
        in_valid1 = 1'b0;
        a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
        exp = sb1.pop_front();
        check({tag, "_result"}, result1, exp[0]);
        check({tag, "_cout"}, cout1, exp[1]);
        tick();
        check({tag, "_post_ready"}, in_ready1, 1);
    endtask

    initial begin
        logic [8:0] exp;
        int seen;
        int lat;

        // Reset state
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", {cout, result}, 0);
        check("rst_slice_outs", {s_c_sel, s_in_xor, s_in_and, s_cin}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #4;

        // 1. Basic add, latency and c_sel pattern
        run_op(8'h5A, 8'h3C, 1'b0, 0, "t1_5a_3c");
        // 2. Carry propagation and carry-in load on step 0
        run_op(8'hFF, 8'h01, 1'b0, 0, "t2_ff_01");
        run_op(8'hFF, 8'h00, 1'b1, 0, "t2_ff_00_cin");
        // 3. Backpressure with an ignored mid-DONE request
        run_op(8'h12, 8'h34, 1'b0, 5, "t3_bp");

        // 4. Asynchronous reset at step 3
        a = 8'h80; b = 8'h80; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        #1 rst = 1'b1;
        #1;
        check("t4_rst_in_ready", in_ready, 1);
        check("t4_rst_out_valid", out_valid, 0);
        check("t4_rst_slice_outs", {s_c_sel, s_in_xor, s_in_and, s_cin}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("t4_no_out_valid", seen, 0);
        run_op(8'h80, 8'h80, 1'b0, 0, "t4_after_rst");

        // 5. Back-to-back with in_valid held high
        a = 8'h01; b = 8'h01; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        sb.push_back(9'h002);
        a = 8'h7F; b = 8'h01;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("t5_first_latency", lat, 9);
        exp = sb.pop_front();
        check("t5_first_result", {cout, result}, exp);
        tick();
        check("t5_idle_ready", in_ready, 1);
        tick();
        sb.push_back(9'h080);
        in_valid = 1'b0;
        check("t5_second_accept", {in_ready, s_c_sel}, 2'b00);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("t5_second_latency", lat, 9);
        exp = sb.pop_front();
        check("t5_second_result", {cout, result}, exp);
        tick();

        // 6. W=1 instance
        check("t6_w1_rst_ready", in_ready1, 1);
        run_op1(1'b1, 1'b1, 1'b1, "t6_w1_111");
        run_op1(1'b0, 1'b0, 1'b0, "t6_w1_000");
        run_op1(1'b1, 1'b0, 1'b1, "t6_w1_101");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
